// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage hold/scour flags, PC redirect, multi-cycle EX watchdog.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
//
// state   | meaning
// RUN     | normal issue; resolves load-use, redirects and multi-cycle starts
// MC_WAIT | multi-cycle EX op in flight; front end held, watchdog counting
// FLUSH   | IF/ID scoured for the remaining redirect drain cycles
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MC_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_rs1_re_i,
  input  logic        id_rs2_re_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        ex_is_load_i,
  input  logic        ex_reg_we_i,
  input  logic [4:0]  ex_reg_waddr_i,
  input  logic        ex_mc_start_i,
  input  logic        ex_mc_done_i,
  input  logic        ex_jump_req_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        mem_stall_req_i,
  output logic        pc_hold_flag_o,
  output logic        if_hold_flag_o,
  output logic        ex_hold_flag_o,
  output logic        if_scour_flag_o,
  output logic        ex_scour_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  output logic        mc_timeout_o
);

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WD_LAST    = 8'(MC_TIMEOUT - 1);

  state_t      state, state_n;
  logic [3:0]  flush_cnt, flush_n;
  logic [7:0]  wd_cnt, wd_n, wd_inc;
  logic        load_use;
  logic        pc_hold, if_hold, ex_hold, if_scour, ex_scour, jump, timeout;
  logic [31:0] jaddr;

  assign load_use = ex_is_load_i & ex_reg_we_i & (ex_reg_waddr_i != 5'd0) &
                    ((id_rs1_re_i & (id_rs1_addr_i == ex_reg_waddr_i)) |
                     (id_rs2_re_i & (id_rs2_addr_i == ex_reg_waddr_i)));
  assign wd_inc = wd_cnt + 8'd1;

  always_comb begin
    pc_hold  = 1'b0;
    if_hold  = 1'b0;
    ex_hold  = 1'b0;
    if_scour = 1'b0;
    ex_scour = 1'b0;
    jump     = 1'b0;
    timeout  = 1'b0;
    jaddr    = 32'd0;
    state_n  = state;
    flush_n  = flush_cnt;
    wd_n     = wd_cnt;
    if (!rst_n) begin
      state_n = RUN;
    end else if (mem_stall_req_i) begin
      pc_hold = 1'b1;
      if_hold = 1'b1;
      ex_hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_mc_start_i) begin
            pc_hold = 1'b1;
            if_hold = 1'b1;
            ex_hold = 1'b1;
            wd_n    = 8'd0;
            state_n = MC_WAIT;
          end else if (ex_jump_req_i) begin
            jump     = 1'b1;
            jaddr    = ex_jump_addr_i;
            if_scour = 1'b1;
            ex_scour = 1'b1;
            flush_n  = FLUSH_LOAD;
            state_n  = (FLUSH_LOAD != 4'd0) ? FLUSH : RUN;
          end else if (load_use) begin
            pc_hold  = 1'b1;
            if_hold  = 1'b1;
            ex_scour = 1'b1;
          end
        end
        MC_WAIT: begin
          if (ex_mc_done_i) begin
            state_n = RUN;
          end else begin
            pc_hold = 1'b1;
            if_hold = 1'b1;
            ex_hold = 1'b1;
            wd_n    = wd_inc;
            if (wd_inc == WD_LAST) begin
              timeout  = 1'b1;
              ex_scour = 1'b1;
              state_n  = RUN;
            end
          end
        end
        FLUSH: begin
          if_scour = 1'b1;
          if (ex_jump_req_i) begin
            jump     = 1'b1;
            jaddr    = ex_jump_addr_i;
            ex_scour = 1'b1;
            flush_n  = FLUSH_LOAD;
            state_n  = (FLUSH_LOAD != 4'd0) ? FLUSH : RUN;
          end else if (flush_cnt <= 4'd1) begin
            flush_n = 4'd0;
            state_n = RUN;
          end else begin
            flush_n = flush_cnt - 4'd1;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  // A scoured register must not also hold, or the NOP would never load.
  assign pc_hold_flag_o  = pc_hold;
  assign if_hold_flag_o  = if_hold & ~if_scour;
  assign ex_hold_flag_o  = ex_hold & ~ex_scour;
  assign if_scour_flag_o = if_scour;
  assign ex_scour_flag_o = ex_scour;
  assign jump_flag_o     = jump;
  assign jump_addr_o     = jaddr;
  assign mc_timeout_o    = timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
      wd_cnt    <= 8'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_n;
      wd_cnt    <= wd_n;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (pc_hold_flag_o) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (jump_flag_o)    flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expected flags; a negedge monitor compares.
module tb_pipe_ctrl;
  localparam logic [6:0] NONE  = 7'b0000000;
  localparam logic [6:0] HOLD3 = 7'b1110000;
  localparam logic [6:0] LU    = 7'b1100100;
  localparam logic [6:0] JMP   = 7'b0001110;
  localparam logic [6:0] FLS   = 7'b0001000;
  localparam logic [6:0] TO    = 7'b0000101;
  localparam logic [6:0] ALL   = 7'b1111111;
  localparam logic [6:0] TO_M  = 7'b0011111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_rs1_re_i, id_rs2_re_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
  logic        ex_is_load_i, ex_reg_we_i;
  logic [4:0]  ex_reg_waddr_i;
  logic        ex_mc_start_i, ex_mc_done_i, ex_jump_req_i;
  logic [31:0] ex_jump_addr_i;
  logic        mem_stall_req_i;
  logic        pc_hold_flag_o, if_hold_flag_o, ex_hold_flag_o;
  logic        if_scour_flag_o, ex_scour_flag_o, jump_flag_o, mc_timeout_o;
  logic [31:0] jump_addr_o;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(2), .MC_TIMEOUT(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1_re_i     (id_rs1_re_i),
    .id_rs2_re_i     (id_rs2_re_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_reg_we_i     (ex_reg_we_i),
    .ex_reg_waddr_i  (ex_reg_waddr_i),
    .ex_mc_start_i   (ex_mc_start_i),
    .ex_mc_done_i    (ex_mc_done_i),
    .ex_jump_req_i   (ex_jump_req_i),
    .ex_jump_addr_i  (ex_jump_addr_i),
    .mem_stall_req_i (mem_stall_req_i),
    .pc_hold_flag_o  (pc_hold_flag_o),
    .if_hold_flag_o  (if_hold_flag_o),
    .ex_hold_flag_o  (ex_hold_flag_o),
    .if_scour_flag_o (if_scour_flag_o),
    .ex_scour_flag_o (ex_scour_flag_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cnt_o     (stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .mc_timeout_o    (mc_timeout_o)
  );

  typedef struct {
    string       name;
    logic [6:0]  flags;
    logic [6:0]  mask;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Monitor: flags are combinational, so every cycle with a pushed expectation is compared.
  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_hold_flag_o, if_hold_flag_o, ex_hold_flag_o, if_scour_flag_o,
             ex_scour_flag_o, jump_flag_o, mc_timeout_o};
      n_cmp++;
      if ((((act ^ e.flags) & e.mask) !== 7'b0) || (jump_addr_o !== e.addr)) begin
        n_err++;
        $display("FAIL %s: got flags=%b addr=%h, expected flags=%b (mask %b) addr=%h",
                 e.name, act, jump_addr_o, e.flags, e.mask, e.addr);
      end
    end
  end

  task automatic idle();
    id_rs1_re_i = 0; id_rs2_re_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
    ex_is_load_i = 0; ex_reg_we_i = 0; ex_reg_waddr_i = 0;
    ex_mc_start_i = 0; ex_mc_done_i = 0; ex_jump_req_i = 0; ex_jump_addr_i = 0;
    mem_stall_req_i = 0;
  endtask

  task automatic load_use(input logic r1e, input logic [4:0] r1, input logic r2e,
                          input logic [4:0] r2, input logic [4:0] wa);
    id_rs1_re_i = r1e; id_rs1_addr_i = r1; id_rs2_re_i = r2e; id_rs2_addr_i = r2;
    ex_is_load_i = 1; ex_reg_we_i = 1; ex_reg_waddr_i = wa;
  endtask

  task automatic jmp(input logic [31:0] a);
    ex_jump_req_i = 1; ex_jump_addr_i = a;
  endtask

  task automatic step(input string name, input logic [6:0] f, input logic [31:0] a,
                      input logic [6:0] m);
    exp_t e;
    e.name = name; e.flags = f; e.mask = m; e.addr = a;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 0;
    @(posedge clk); #1;
    // Reset masks all outputs even with requests present.
    jmp(32'hdead_beef); load_use(1, 5'd3, 0, 5'd0, 5'd3);
    step("reset_out", NONE, 0, ALL);
    step("reset_out2", NONE, 0, ALL);
    rst_n = 1; idle();
    step("idle", NONE, 0, ALL);

    load_use(0, 5'd0, 1, 5'd5, 5'd5);
    step("lu_rs2", LU, 0, ALL);
    idle();
    step("lu_after", NONE, 0, ALL);
    load_use(1, 5'd7, 0, 5'd0, 5'd7);
    step("lu_rs1", LU, 0, ALL);
    load_use(1, 5'd0, 1, 5'd0, 5'd0);
    step("lu_x0", NONE, 0, ALL);
    load_use(0, 5'd9, 0, 5'd9, 5'd9);
    step("lu_no_re", NONE, 0, ALL);
    idle(); ex_reg_we_i = 1; ex_reg_waddr_i = 5'd4; id_rs1_re_i = 1; id_rs1_addr_i = 5'd4;
    step("lu_not_load", NONE, 0, ALL);

    idle(); jmp(32'h0000_0100);
    step("redir_n", JMP, 32'h100, ALL);
    idle();
    step("redir_n1", FLS, 0, ALL);
    step("redir_n2", NONE, 0, ALL);

    jmp(32'h200);
    step("redir2", JMP, 32'h200, ALL);
    jmp(32'h300);
    step("redir_in_flush", JMP, 32'h300, ALL);
    idle();
    step("reload_flush", FLS, 0, ALL);
    step("reload_done", NONE, 0, ALL);

    jmp(32'h400);
    step("redir4", JMP, 32'h400, ALL);
    idle(); load_use(1, 5'd6, 0, 5'd0, 5'd6);
    step("lu_in_flush", FLS, 0, ALL);
    idle();
    step("after_flush_lu", NONE, 0, ALL);

    ex_mc_start_i = 1;
    step("mc_start", HOLD3, 0, ALL);
    idle();
    for (int i = 1; i <= 32; i++) begin
      if (i == 5) jmp(32'h500);
      step("mc_hold", HOLD3, 0, ALL);
      idle();
    end
    ex_mc_done_i = 1;
    step("mc_done", NONE, 0, ALL);
    idle();
    step("mc_after", NONE, 0, ALL);

    ex_mc_start_i = 1; ex_mc_done_i = 1;
    step("start_done_same", HOLD3, 0, ALL);
    idle();
    step("start_done_wait", HOLD3, 0, ALL);
    ex_mc_done_i = 1;
    step("start_done_rel", NONE, 0, ALL);
    idle();

    // Watchdog: three mem_stall cycles inside MC_WAIT freeze it, pushing the expiry out by three.
    ex_mc_start_i = 1;
    step("wd_start", HOLD3, 0, ALL);
    idle();
    for (int i = 1; i <= 9; i++) step("wd_hold_a", HOLD3, 0, ALL);
    mem_stall_req_i = 1;
    for (int i = 0; i < 3; i++) step("wd_mem_frz", HOLD3, 0, ALL);
    idle();
    for (int i = 0; i < 53; i++) step("wd_hold_b", HOLD3, 0, ALL);
    step("wd_timeout", TO, 0, TO_M);
    step("wd_run", NONE, 0, ALL);

    mem_stall_req_i = 1; jmp(32'h600); load_use(1, 5'd8, 0, 5'd0, 5'd8);
    step("mem_prio", HOLD3, 0, ALL);
    step("mem_prio2", HOLD3, 0, ALL);
    mem_stall_req_i = 0;
    step("jump_after_mem", JMP, 32'h600, ALL);
    idle();
    step("jump_after_mem_fl", FLS, 0, ALL);
    step("jump_after_mem_end", NONE, 0, ALL);

    ex_mc_start_i = 1; jmp(32'h700);
    step("mc_over_jump", HOLD3, 0, ALL);
    idle(); ex_mc_done_i = 1;
    step("mc_over_jump_done", NONE, 0, ALL);
    idle();

    jmp(32'h800); load_use(0, 5'd0, 1, 5'd2, 5'd2);
    step("jump_over_lu", JMP, 32'h800, ALL);
    idle();
    step("jump_over_lu_fl", FLS, 0, ALL);
    step("jump_over_lu_end", NONE, 0, ALL);

    jmp(32'h900);
    step("rst_flush_jmp", JMP, 32'h900, ALL);
    idle(); rst_n = 0;
    step("rst_in_flush", NONE, 0, ALL);
`ifdef PIPE_CTRL_PERF_CNT_EN
    n_cmp++;
    if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL perf_cnt_reset: got stall=%0d flush=%0d, expected 0 and 0",
               stall_cnt_o, flush_cnt_o);
    end
`endif
    rst_n = 1;
    step("rst_flush_run", NONE, 0, ALL);
    step("rst_flush_run2", NONE, 0, ALL);

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
